// File: rtl/sha_const.sv
// SHA-2 shared constants: round constants, IV tables, FSM encoding and
// the bit-mixing functions used by both SHA-2 word widths (32/64).
package sha_const;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    localparam logic [31:0] K256 [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd,
        64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019,
        64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe,
        64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
        64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
        64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
        64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210,
        64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
        64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
        64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
        64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
        64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910,
        64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
        64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
        64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
        64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9,
        64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207,
        64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
        64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493,
        64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
        64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // IVs packed {H0..H7}, H0 in the MSBs
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [511:0] IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
        64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511,
        64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [511:0] IV512_224 = {
        64'h8c3d37c819544da2, 64'h73e1996689dcd4d6,
        64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
        64'h0f6d2b697bd44da8, 64'h77e36f7304c48942,
        64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1
    };
    localparam logic [511:0] IV512_256 = {
        64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2,
        64'h2393b86b6f53b151, 64'h963877195940eabd,
        64'h96283ee2a88effe3, 64'hbe5e1e2553863992,
        64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2
    };

    // Words travel zero-extended in 64 bits; w selects the active width.
    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? {64{1'b1}} : 64'h0000_0000_ffff_ffff;
    endfunction

    function automatic logic [63:0] ROTR(
        input logic [63:0] x, input int n, input int w);
        logic [63:0] m;
        m = wmask(w);
        return (((x & m) >> n) | ((x & m) << (w - n))) & m;
    endfunction

    function automatic logic [63:0] SHR(
        input logic [63:0] x, input int n, input int w);
        return (x & wmask(w)) >> n;
    endfunction

    function automatic logic [63:0] CH(
        input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [63:0] MAJ(
        input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // sel=0: Sigma0, sel=1: Sigma1
    function automatic logic [63:0] BIGSIGMA(
        input logic [63:0] x, input logic sel, input int w);
        if (w == 32)
            return sel ? ROTR(x, 6, w) ^ ROTR(x, 11, w) ^ ROTR(x, 25, w)
                       : ROTR(x, 2, w) ^ ROTR(x, 13, w) ^ ROTR(x, 22, w);
        return sel ? ROTR(x, 14, w) ^ ROTR(x, 18, w) ^ ROTR(x, 41, w)
                   : ROTR(x, 28, w) ^ ROTR(x, 34, w) ^ ROTR(x, 39, w);
    endfunction

    // sel=0: sigma0, sel=1: sigma1
    function automatic logic [63:0] SMALLSIGMA(
        input logic [63:0] x, input logic sel, input int w);
        if (w == 32)
            return sel ? ROTR(x, 17, w) ^ ROTR(x, 19, w) ^ SHR(x, 10, w)
                       : ROTR(x, 7, w) ^ ROTR(x, 18, w) ^ SHR(x, 3, w);
        return sel ? ROTR(x, 19, w) ^ ROTR(x, 61, w) ^ SHR(x, 6, w)
                   : ROTR(x, 1, w) ^ ROTR(x, 8, w) ^ SHR(x, 7, w);
    endfunction

    function automatic logic [63:0] k_word(input logic [6:0] t, input int w);
        if (w == 32)
            return {32'h0, K256[t[5:0]]};
        return K512[t];
    endfunction

    // WIDTH=32 returns the IV in the low 256 bits.
    function automatic logic [511:0] iv_sel(input logic [1:0] op, input int w);
        if (w == 32)
            return (op == 2'd0) ? {256'h0, IV224} : {256'h0, IV256};
        case (op)
            2'd0:    return IV384;
            2'd1:    return IV512;
            2'd2:    return IV512_224;
            default: return IV512_256;
        endcase
    endfunction

endpackage

// File: rtl/sha2_core_if.sv
// Block-feeding bus between the padding front end (master) and sha2_core
// (slave): Data/Index/Operation/Enable in, Hash/Ready/Busy out.
interface sha2_core_if #(
    parameter int WIDTH = 32
);
    logic [16*WIDTH-1:0] Data;
    logic [63:0]         Index;
    logic [1:0]          Operation;
    logic                Enable;
    logic [8*WIDTH-1:0]  Hash;
    logic                Ready;
    logic                Busy;

    modport master (
        output Data, Index, Operation, Enable,
        input  Hash, Ready, Busy
    );

    modport slave (
        input  Data, Index, Operation, Enable,
        output Hash, Ready, Busy
    );
endinterface

// File: rtl/sha2_sched.sv
// Rolling 16-word message schedule window. Ports: clk, rst (async low),
// load (capture data), shift (advance one word), data, w_t = window[0].
module sha2_sched
    import sha_const::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [16*WIDTH-1:0] data,
    output logic [WIDTH-1:0]    w_t
);
    logic [WIDTH-1:0] w [0:15];
    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;

    always_comb begin
        s0    = WIDTH'(SMALLSIGMA(64'(w[1]), 1'b0, WIDTH));
        s1    = WIDTH'(SMALLSIGMA(64'(w[14]), 1'b1, WIDTH));
        w_new = s1 + w[9] + s0 + w[0];
    end

    assign w_t = w[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                w[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++)
                w[i] <= data[i*WIDTH +: WIDTH];
        end else if (shift) begin
            for (int i = 0; i < 15; i++)
                w[i] <= w[i+1];
            w[15] <= w_new;
        end
    end
endmodule

// File: rtl/sha2_core.sv
// SHA-2 compression engine, one round per clock, WIDTH 32 or 64.
// Ports: clk, rst (async low), bus (slave: Data/Index/Operation/Enable in,
// Hash/Ready/Busy out, all outputs registered).
module sha2_core
    import sha_const::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    sha2_core_if.slave  bus
);
    localparam int         R      = (WIDTH == 64) ? 80 : 64;
    localparam logic [6:0] T_LAST = 7'(R - 1);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("sha2_core: WIDTH must be 32 or 64");
    end

    typedef logic [WIDTH-1:0] word_t;

    state_t              state;
    logic [6:0]          t;
    word_t               v  [0:7];
    word_t               hb [0:7];
    logic [8*WIDTH-1:0]  hash_q;
    logic                ready_q;
    logic                busy_q;

    logic                sched_load;
    logic                sched_shift;
    word_t               w_t;
    word_t               k_t;
    word_t               s0;
    word_t               s1;
    word_t               chv;
    word_t               mjv;
    word_t               t1;
    word_t               t2;
    logic [8*WIDTH-1:0]  iv_vec;
    logic                from_iv;

    assign bus.Hash  = hash_q;
    assign bus.Ready = ready_q;
    assign bus.Busy  = busy_q;

    assign sched_load  = (state == ST_IDLE) && bus.Enable;
    assign sched_shift = (state == ST_ROUND);

    sha2_sched #(.WIDTH(WIDTH)) u_sched (
        .clk   (clk),
        .rst   (rst),
        .load  (sched_load),
        .shift (sched_shift),
        .data  (bus.Data),
        .w_t   (w_t)
    );

    always_comb begin
        iv_vec  = (8*WIDTH)'(iv_sel(bus.Operation, WIDTH));
        from_iv = (bus.Index == 64'd1);
        k_t     = word_t'(k_word(t, WIDTH));
        s0      = word_t'(BIGSIGMA(64'(v[0]), 1'b0, WIDTH));
        s1      = word_t'(BIGSIGMA(64'(v[4]), 1'b1, WIDTH));
        chv     = word_t'(CH(64'(v[4]), 64'(v[5]), 64'(v[6])));
        mjv     = word_t'(MAJ(64'(v[0]), 64'(v[1]), 64'(v[2])));
        t1      = v[7] + s1 + chv + k_t + w_t;
        t2      = s0 + mjv;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            t       <= '0;
            hash_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                v[i]  <= '0;
                hb[i] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.Enable) begin
                        // base H is latched so Operation may change mid-block
                        for (int i = 0; i < 8; i++) begin
                            v[i]  <= from_iv ? iv_vec[(7-i)*WIDTH +: WIDTH]
                                             : hash_q[(7-i)*WIDTH +: WIDTH];
                            hb[i] <= from_iv ? iv_vec[(7-i)*WIDTH +: WIDTH]
                                             : hash_q[(7-i)*WIDTH +: WIDTH];
                        end
                        t      <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    v[0] <= t1 + t2;
                    v[1] <= v[0];
                    v[2] <= v[1];
                    v[3] <= v[2];
                    v[4] <= v[3] + t1;
                    v[5] <= v[4];
                    v[6] <= v[5];
                    v[7] <= v[6];
                    t    <= t + 7'd1;
                    if (t == T_LAST)
                        state <= ST_FINAL;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++)
                        hash_q[(7-i)*WIDTH +: WIDTH] <= v[i] + hb[i];
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha2_core.sv
// Directed bench for sha2_core at WIDTH=32 and WIDTH=64 using
// FIPS 180-4 example vectors.
module tb_sha2_core;
    logic clk = 1'b0;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   lat;

    always #5 clk = ~clk;

    sha2_core_if #(.WIDTH(32)) bus32 ();
    sha2_core_if #(.WIDTH(64)) bus64 ();

    sha2_core #(.WIDTH(32)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    sha2_core #(.WIDTH(64)) u64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    // word i lives at Data[i*W +: W]
    localparam logic [511:0] ABC32 =
        {32'h00000018, {14{32'h0}}, 32'h61626380};
    localparam logic [511:0] TWO_B1 = {
        32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70,
        32'h6c6d6e6f, 32'h6b6c6d6e, 32'h6a6b6c6d, 32'h696a6b6c,
        32'h68696a6b, 32'h6768696a, 32'h66676869, 32'h65666768,
        32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364
    };
    localparam logic [511:0] TWO_B2 = {32'h000001c0, 480'h0};
    localparam logic [1023:0] ABC64 =
        {64'h18, {14{64'h0}}, 64'h6162638000000000};

    localparam logic [511:0] D256_ABC = {256'h0,
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
    localparam logic [511:0] D224_ABC = {288'h0,
        224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7};
    localparam logic [511:0] D256_TWO = {256'h0,
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};
    localparam logic [511:0] D512_ABC = {
        256'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a,
        256'h2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f};
    localparam logic [511:0] D384_ABC = {128'h0,
        128'hcb00753f45a35e8bb5a03d699ac65007,
        128'h272c32ab0eded1631a8b605a43ff5bed,
        128'h8086072ba1e7cc2358baeca134c825a7};

    task automatic check(input string tag,
                         input logic [511:0] got,
                         input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go32(input logic [511:0] d,
                        input logic [63:0] idx,
                        input logic [1:0] op);
        bus32.Data      = d;
        bus32.Index     = idx;
        bus32.Operation = op;
        bus32.Enable    = 1'b1;
        @(posedge clk);
        #1;
        bus32.Enable = 1'b0;
    endtask

    task automatic go64(input logic [1023:0] d,
                        input logic [63:0] idx,
                        input logic [1:0] op);
        bus64.Data      = d;
        bus64.Index     = idx;
        bus64.Operation = op;
        bus64.Enable    = 1'b1;
        @(posedge clk);
        #1;
        bus64.Enable = 1'b0;
    endtask

    task automatic wait32(input int start, output int n);
        n = start;
        while (!bus32.Ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait64(input int start, output int n);
        n = start;
        while (!bus64.Ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        bus32.Data = '0; bus32.Index = '0;
        bus32.Operation = '0; bus32.Enable = 1'b0;
        bus64.Data = '0; bus64.Index = '0;
        bus64.Operation = '0; bus64.Enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hash32", 512'(bus32.Hash), 512'h0);
        check("rst_ready32", 512'(bus32.Ready), 512'h0);
        check("rst_busy32", 512'(bus32.Busy), 512'h0);
        check("rst_hash64", bus64.Hash, 512'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // SHA-256 "abc"
        go32(ABC32, 64'd1, 2'd1);
        check("busy_accept", 512'(bus32.Busy), 512'h1);
        wait32(0, lat);
        check("lat256", 512'(lat), 512'd65);
        check("busy_done", 512'(bus32.Busy), 512'h0);
        check("sha256_abc", 512'(bus32.Hash), D256_ABC);
        @(posedge clk);
        #1;
        check("ready_pulse", 512'(bus32.Ready), 512'h0);
        check("hash_hold", 512'(bus32.Hash), D256_ABC);

        // SHA-224 "abc"
        go32(ABC32, 64'd1, 2'd0);
        wait32(0, lat);
        check("lat224", 512'(lat), 512'd65);
        check("sha224_abc", 512'(bus32.Hash[255:32]), D224_ABC);

        // Operation 2 behaves as SHA-256
        go32(ABC32, 64'd1, 2'd2);
        wait32(0, lat);
        check("op2_is_256", 512'(bus32.Hash), D256_ABC);

        // two-block message, second block fed in the Ready cycle
        go32(TWO_B1, 64'd1, 2'd1);
        wait32(0, lat);
        check("lat_blk1", 512'(lat), 512'd65);
        go32(TWO_B2, 64'd2, 2'd1);
        check("b2b_busy", 512'(bus32.Busy), 512'h1);
        wait32(0, lat);
        check("lat_blk2", 512'(lat), 512'd65);
        check("sha256_two", 512'(bus32.Hash), D256_TWO);

        // Enable while busy is ignored
        go32(ABC32, 64'd1, 2'd1);
        repeat (9) @(posedge clk);
        #1;
        bus32.Data      = TWO_B1;
        bus32.Index     = 64'd2;
        bus32.Operation = 2'd0;
        bus32.Enable    = 1'b1;
        @(posedge clk);
        #1;
        bus32.Enable = 1'b0;
        check("ign_busy", 512'(bus32.Busy), 512'h1);
        wait32(10, lat);
        check("ign_lat", 512'(lat), 512'd65);
        check("ign_hash", 512'(bus32.Hash), D256_ABC);

        // SHA-512 / SHA-384 "abc"
        go64(ABC64, 64'd1, 2'd1);
        check("busy64", 512'(bus64.Busy), 512'h1);
        wait64(0, lat);
        check("lat512", 512'(lat), 512'd81);
        check("sha512_abc", bus64.Hash, D512_ABC);
        go64(ABC64, 64'd1, 2'd0);
        wait64(0, lat);
        check("sha384_abc", 512'(bus64.Hash[511:128]), D384_ABC);

        // reset in the middle of a block, then reissue
        go32(ABC32, 64'd1, 2'd1);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_hash", 512'(bus32.Hash), 512'h0);
        check("mid_rst_ready", 512'(bus32.Ready), 512'h0);
        check("mid_rst_busy", 512'(bus32.Busy), 512'h0);
        check("mid_rst_hash64", bus64.Hash, 512'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        go32(ABC32, 64'd1, 2'd1);
        wait32(0, lat);
        check("post_rst_lat", 512'(lat), 512'd65);
        check("post_rst_hash", 512'(bus32.Hash), D256_ABC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
